regfile_loader: RTL

- Preloads the architectural register file before a program runs. It is the writing counterpart of the harness that scans registers out after a run.
- It sits between the processor's regfile write port and the regfile, and takes a valid/ready word stream.
- While loading, it holds the processor and owns the write port. When idle, it passes the processor's write signals through unchanged.

---
 rtl/regfile_loader.sv | 106 ++++++++++
 1 files changed

// File: rtl/regfile_loader.sv
// Preloads the register file from a valid/ready word stream while holding the CPU; passes CPU writes through when idle.
// Latency: start -> first in_ready 1 cycle; stream words write same cycle; done 1 cycle after last accept.
// Backpressure: in_ready is high for the whole LOAD state; in_valid low simply stalls the sequence.
module regfile_loader #(
    parameter int NUM_REGS   = 32,
    parameter int START_REG  = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  cpu_we,
    input  logic [4:0]            cpu_rd,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  rf_we,
    output logic [4:0]            rf_rd,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam logic [4:0] FIRST_IDX = 5'(START_REG);
    localparam logic [4:0] LAST_IDX  = 5'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [4:0]            idx_q, idx_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;

    assign checksum = sum_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        cpu_hold = 1'b0;
        done     = 1'b0;
        rf_we    = cpu_we;
        rf_rd    = cpu_rd;
        rf_wdata = cpu_wdata;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    idx_d   = FIRST_IDX;
                    sum_d   = '0;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                // The regfile captures the stream word on the same edge that accepts it.
                rf_we    = in_valid;
                rf_rd    = idx_q;
                rf_wdata = in_data;
                if (in_valid) begin
                    sum_d = sum_q + in_data;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                rf_we    = 1'b0;
                rf_rd    = idx_q;
                rf_wdata = in_data;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= FIRST_IDX;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
        end
    end

endmodule
